// File: rtl/eq_cfg_pkg.sv
// rtl/eq_cfg_pkg.sv - FSM encoding, defaults and preset ROM contents for eq_gain_sequencer
package eq_cfg_pkg;

  localparam int         NUM_BANDS_DEF   = 10;
  localparam int         NUM_PRESETS_DEF = 4;
  localparam logic [7:0] UNITY_CODE_DEF  = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST_WR,
    ST_PRE_WR,
    ST_RAMP_WAIT,
    ST_RAMP_SWEEP,
    ST_DONE
  } eq_state_e;

  // Preset 0 is flat, preset 1 a rising tilt, presets 2/3 a gentle rise and a gentle fall.
  function automatic logic [7:0] preset_code(input logic [7:0] preset, input logic [7:0] band);
    logic [7:0] code;
    case (preset)
      8'd0:    code = UNITY_CODE_DEF;
      8'd1:    code = 8'h80 + (band << 3);
      8'd2:    code = 8'h60 + (band << 2);
      default: code = 8'hA0 - (band << 2);
    endcase
    return code;
  endfunction

endpackage

// File: rtl/eq_preset_rom.sv
// rtl/eq_preset_rom.sv - combinational preset ROM: (preset index, band) -> 8-bit gain code
module eq_preset_rom
  import eq_cfg_pkg::*;
#(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [7:0]       band,
  output logic [7:0]       code
);

  always_comb code = preset_code(8'(sel), band);

endmodule

// File: rtl/eq_gain_sequencer.sv
// rtl/eq_gain_sequencer.sv - gain-bank write sequencer arbitrating host writes and preset loads
// Optional soft preset ramp when EQ_GAIN_SOFT_RAMP_EN is defined.
module eq_gain_sequencer
  import eq_cfg_pkg::*;
#(
  parameter int         NUM_BANDS   = NUM_BANDS_DEF,
  parameter int         NUM_PRESETS = NUM_PRESETS_DEF,
  parameter logic [7:0] UNITY_CODE  = UNITY_CODE_DEF,
  parameter int         STEP_DIV    = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           host_req,
  input  logic [7:0]                     host_addr,
  input  logic [7:0]                     host_data,
  output logic                           host_ack,
  output logic                           host_err,
  input  logic                           preset_req,
  input  logic [$clog2(NUM_PRESETS)-1:0] preset_sel,
  output logic                           preset_busy,
  output logic                           preset_done,
  output logic                           we,
  output logic [7:0]                     addr,
  output logic [7:0]                     data_out
);

  localparam int         SEL_W    = $clog2(NUM_PRESETS);
  localparam int         BW       = $clog2(NUM_BANDS);
  localparam logic [7:0] BAND_END = 8'(NUM_BANDS);

  eq_state_e        state_q, state_d;
  logic [7:0]       band_q, band_d;
  logic [SEL_W-1:0] sel_q, sel_d, rom_sel;
  logic [7:0]       shadow_q [NUM_BANDS];
  logic [7:0]       shadow_d [NUM_BANDS];
  logic [7:0]       rom_code [NUM_BANDS];
  logic             we_q, we_d, host_ack_q, host_ack_d, host_err_q, host_err_d;
  logic             preset_busy_q, preset_busy_d, preset_done_q, preset_done_d;
  logic [7:0]       addr_q, addr_d, data_q, data_d;
  logic             host_go, host_ok;
  logic [BW-1:0]    host_idx, band_idx;

  assign host_ok  = host_addr < BAND_END;
  assign host_idx = host_addr[BW-1:0];
  assign band_idx = band_q[BW-1:0];
  // Live select while idle so acceptance can use the codes in the same cycle.
  assign rom_sel  = (state_q == ST_IDLE) ? preset_sel : sel_q;

  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_rom
    eq_preset_rom #(.SEL_W(SEL_W)) u_rom (
      .sel  (rom_sel),
      .band (8'(g)),
      .code (rom_code[g])
    );
  end

`ifdef EQ_GAIN_SOFT_RAMP_EN
  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [TW-1:0] tick_q, tick_d;
  logic          tick, all_eq, ret_q, ret_d, pend_q, pend_d;
  logic [7:0]    target_q [NUM_BANDS];
  logic [7:0]    target_d [NUM_BANDS];
  logic [7:0]    cur, tgt;

  assign tick = (tick_q == TW'(STEP_DIV - 1));
  assign cur  = shadow_q[band_idx];
  assign tgt  = target_q[band_idx];

  always_comb begin
    tick_d = tick ? '0 : tick_q + 1'b1;
    all_eq = 1'b1;
    for (int i = 0; i < NUM_BANDS; i++)
      if (shadow_q[i] != target_q[i]) all_eq = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q <= '0;
      ret_q  <= 1'b0;
      pend_q <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) target_q[i] <= UNITY_CODE;
    end else begin
      tick_q   <= tick_d;
      ret_q    <= ret_d;
      pend_q   <= pend_d;
      target_q <= target_d;
    end
  end
`endif

  // Outputs are registered: each state computes what the bank sees in the following cycle.
  always_comb begin
    state_d       = state_q;
    band_d        = band_q;
    sel_d         = sel_q;
    shadow_d      = shadow_q;
    we_d          = 1'b0;
    addr_d        = '0;
    data_d        = '0;
    host_ack_d    = 1'b0;
    host_err_d    = 1'b0;
    preset_busy_d = preset_busy_q;
    preset_done_d = 1'b0;
    host_go       = 1'b0;
`ifdef EQ_GAIN_SOFT_RAMP_EN
    target_d = target_q;
    ret_d    = ret_q;
    pend_d   = pend_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (host_req) begin
          host_go = 1'b1;
`ifdef EQ_GAIN_SOFT_RAMP_EN
          ret_d = 1'b0;
`endif
        end else if (preset_req) begin
          sel_d         = preset_sel;
          preset_busy_d = 1'b1;
`ifdef EQ_GAIN_SOFT_RAMP_EN
          target_d = rom_code;
          state_d  = ST_RAMP_WAIT;
`else
          we_d        = 1'b1;
          data_d      = rom_code[0];
          shadow_d[0] = rom_code[0];
          band_d      = 8'd1;
          state_d     = ST_PRE_WR;
`endif
        end
      end
      ST_HOST_WR: begin
`ifdef EQ_GAIN_SOFT_RAMP_EN
        if (!ret_q) begin
          state_d = ST_IDLE;
        end else if (pend_q || tick) begin
          state_d = ST_RAMP_SWEEP;
          band_d  = '0;
          pend_d  = 1'b0;
        end else begin
          state_d = ST_RAMP_WAIT;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_PRE_WR: begin
        if (band_q == BAND_END) begin
          preset_done_d = 1'b1;
          preset_busy_d = 1'b0;
          state_d       = ST_DONE;
        end else begin
          we_d               = 1'b1;
          addr_d             = band_q;
          data_d             = rom_code[band_idx];
          shadow_d[band_idx] = rom_code[band_idx];
          band_d             = band_q + 8'd1;
        end
      end
`ifdef EQ_GAIN_SOFT_RAMP_EN
      ST_RAMP_WAIT: begin
        if (host_req) begin
          host_go = 1'b1;
          ret_d   = 1'b1;
          pend_d  = tick;
        end else if (tick) begin
          state_d = ST_RAMP_SWEEP;
          band_d  = '0;
        end
      end
      ST_RAMP_SWEEP: begin
        if (band_q == BAND_END) begin
          if (all_eq) begin
            preset_done_d = 1'b1;
            preset_busy_d = 1'b0;
            state_d       = ST_DONE;
          end else begin
            state_d = ST_RAMP_WAIT;
          end
        end else begin
          band_d = band_q + 8'd1;
          if (cur != tgt) begin
            we_d               = 1'b1;
            addr_d             = band_q;
            data_d             = (cur < tgt) ? cur + 8'd1 : cur - 8'd1;
            shadow_d[band_idx] = data_d;
          end
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (host_go) begin
      host_ack_d = 1'b1;
      state_d    = ST_HOST_WR;
      if (host_ok) begin
        we_d               = 1'b1;
        addr_d             = host_addr;
        data_d             = host_data;
        shadow_d[host_idx] = host_data;
`ifdef EQ_GAIN_SOFT_RAMP_EN
        target_d[host_idx] = host_data;
`endif
      end else begin
        host_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      band_q        <= '0;
      sel_q         <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      host_ack_q    <= 1'b0;
      host_err_q    <= 1'b0;
      preset_busy_q <= 1'b0;
      preset_done_q <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) shadow_q[i] <= UNITY_CODE;
    end else begin
      state_q       <= state_d;
      band_q        <= band_d;
      sel_q         <= sel_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      host_ack_q    <= host_ack_d;
      host_err_q    <= host_err_d;
      preset_busy_q <= preset_busy_d;
      preset_done_q <= preset_done_d;
      shadow_q      <= shadow_d;
    end
  end

  assign we          = we_q;
  assign addr        = addr_q;
  assign data_out    = data_q;
  assign host_ack    = host_ack_q;
  assign host_err    = host_err_q;
  assign preset_busy = preset_busy_q;
  assign preset_done = preset_done_q;

endmodule

// File: tb/tb_eq_gain_sequencer.sv
// tb/tb_eq_gain_sequencer.sv - randomized self-checking bench for eq_gain_sequencer
// Ramp scenario is built when EQ_GAIN_SOFT_RAMP_EN is defined.
module tb_eq_gain_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_req = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_data = '0;
  logic       host_ack, host_err;
  logic       preset_req = 1'b0;
  logic [1:0] preset_sel = '0;
  logic       preset_busy, preset_done;
  logic       we;
  logic [7:0] addr, data_out;

  int errors = 0;
  int checks = 0;
  logic [7:0] m_shadow [10];
  logic [7:0] m_bank [10];

  eq_gain_sequencer #(.NUM_BANDS(10), .NUM_PRESETS(4), .UNITY_CODE(8'h80), .STEP_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
    .host_ack(host_ack), .host_err(host_err),
    .preset_req(preset_req), .preset_sel(preset_sel),
    .preset_busy(preset_busy), .preset_done(preset_done),
    .we(we), .addr(addr), .data_out(data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  function automatic logic [7:0] m_rom(input int p, input int b);
    return (p == 0) ? 8'h80 : 8'(8'h80 + 8 * b);
  endfunction

  // Bank model: every strobe seen on the write port, and the port must never leave the bank.
  always @(negedge clk) begin
    if (rst_n && we) begin
      checks++;
      if (addr >= 8'd10) begin
        errors++;
        $display("FAIL addr_range: addr=%0d required <10", addr);
      end else begin
        m_bank[addr[3:0]] = data_out;
      end
    end
  end

  task automatic reset_models();
    for (int i = 0; i < 10; i++) begin
      m_shadow[i] = 8'h80;
      m_bank[i]   = 8'h80;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; host_req = 1'b0; preset_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    reset_models();
    @(negedge clk);
    checks++;
    if ({we, addr, data_out, host_ack, host_err, preset_busy, preset_done} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b addr=%h data=%h ack=%b err=%b busy=%b done=%b required all 0",
               we, addr, data_out, host_ack, host_err, preset_busy, preset_done);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (dut.shadow_q[i] !== 8'h80) begin
        errors++;
        $display("FAIL reset_shadow[%0d]: got %h required 80", i, dut.shadow_q[i]);
      end
    end
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    logic ok;
    ok = (a < 8'd10);
    @(posedge clk); #1;
    host_req = 1'b1; host_addr = a; host_data = d;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({host_ack, host_err, we} !== {1'b1, !ok, ok}) begin
      errors++;
      $display("FAIL host_handshake(a=%0d): ack=%b err=%b we=%b required 1 %b %b", a, host_ack, host_err, we, !ok, ok);
    end
    if (ok) begin
      checks++;
      if ({addr, data_out} !== {a, d}) begin
        errors++;
        $display("FAIL host_bus: addr=%h data=%h required %h %h", addr, data_out, a, d);
      end
      m_shadow[a[3:0]] = d;
    end
    host_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({host_ack, host_err, we} !== 3'b000) begin
      errors++;
      $display("FAIL host_pulse: ack=%b err=%b we=%b required 000", host_ack, host_err, we);
    end
  endtask

  task automatic test_host_write();
    host_write(8'd3, 8'hA0);
    host_write(8'd10, 8'h55);
    host_write(8'd9, 8'h11);
    host_write(8'hFF, 8'h22);
    for (int i = 0; i < 6; i++)
      host_write(8'($urandom_range(0, 12)), 8'($urandom));
  endtask

  task automatic test_request_hold();
    logic [7:0] d1, d2;
    d1 = 8'($urandom); d2 = 8'($urandom);
    @(posedge clk); #1;
    host_req = 1'b1; host_addr = 8'd2; host_data = d1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({host_ack, we, data_out} !== {2'b11, d1}) begin
      errors++;
      $display("FAIL hold_first: ack=%b we=%b data=%h required 1 1 %h", host_ack, we, data_out, d1);
    end
    host_data = d2;
    @(negedge clk);
    checks++;
    if (host_ack !== 1'b0) begin
      errors++;
      $display("FAIL hold_gap: ack=%b required 0", host_ack);
    end
    @(negedge clk);
    checks++;
    if ({host_ack, we, addr, data_out} !== {2'b11, 8'd2, d2}) begin
      errors++;
      $display("FAIL hold_second: ack=%b we=%b addr=%h data=%h required 1 1 02 %h", host_ack, we, addr, data_out, d2);
    end
    host_req = 1'b0;
    m_shadow[2] = d2;
    @(negedge clk);
  endtask

  task automatic test_consistency();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (dut.shadow_q[i] !== m_shadow[i] || m_bank[i] !== m_shadow[i]) begin
        errors++;
        $display("FAIL consistency[%0d]: shadow=%h bank=%h required %h", i, dut.shadow_q[i], m_bank[i], m_shadow[i]);
      end
    end
  endtask

  task automatic test_preset(input int sel);
    @(posedge clk); #1;
    preset_req = 1'b1; preset_sel = 2'(sel);
    @(posedge clk); #1;
    preset_req = 1'b0; preset_sel = ~2'(sel);
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      checks++;
      if ({we, preset_busy, preset_done, addr, data_out} !== {3'b110, 8'(b), m_rom(sel, b)}) begin
        errors++;
        $display("FAIL preset%0d_write[%0d]: we=%b busy=%b done=%b addr=%h data=%h required 1 1 0 %h %h",
                 sel, b, we, preset_busy, preset_done, addr, data_out, 8'(b), m_rom(sel, b));
      end
      m_shadow[b] = m_rom(sel, b);
    end
    @(negedge clk);
    checks++;
    if ({we, preset_busy, preset_done} !== 3'b001) begin
      errors++;
      $display("FAIL preset%0d_done: we=%b busy=%b done=%b required 0 0 1", sel, we, preset_busy, preset_done);
    end
    @(negedge clk);
    checks++;
    if (preset_done !== 1'b0) begin
      errors++;
      $display("FAIL preset%0d_done_pulse: done=%b required 0", sel, preset_done);
    end
  endtask

  task automatic test_collision();
    logic [7:0] d1, d2;
    int done_c, ack_c;
    d1 = 8'($urandom); d2 = 8'($urandom);
    @(posedge clk); #1;
    host_req = 1'b1; host_addr = 8'd7; host_data = d1;
    preset_req = 1'b1; preset_sel = 2'd1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({host_ack, we, addr, data_out, preset_busy} !== {2'b11, 8'd7, d1, 1'b0}) begin
      errors++;
      $display("FAIL collide_host_first: ack=%b we=%b addr=%h data=%h busy=%b required 1 1 07 %h 0",
               host_ack, we, addr, data_out, preset_busy, d1);
    end
    host_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({preset_busy, we, addr, data_out} !== {2'b11, 8'd0, 8'h80}) begin
      errors++;
      $display("FAIL collide_preset_start: busy=%b we=%b addr=%h data=%h required 1 1 00 80", preset_busy, we, addr, data_out);
    end
    preset_req = 1'b0;
    done_c = -1; ack_c = -1;
    for (int c = 1; c <= 30 && ack_c < 0; c++) begin
      @(negedge clk);
      if (preset_done && done_c < 0) done_c = c;
      if (host_ack) begin
        ack_c = c;
        checks++;
        if ({we, addr, data_out} !== {1'b1, 8'd4, d2}) begin
          errors++;
          $display("FAIL collide_late_host: we=%b addr=%h data=%h required 1 04 %h", we, addr, data_out, d2);
        end
        host_req = 1'b0;
      end
      if (c == 2) begin
        host_req = 1'b1; host_addr = 8'd4; host_data = d2;
      end
    end
    checks++;
    if (done_c != 10) begin
      errors++;
      $display("FAIL collide_done_cycle: done at %0d required 10", done_c);
    end
    checks++;
    if (ack_c <= done_c) begin
      errors++;
      $display("FAIL collide_order: ack at %0d done at %0d required ack after done", ack_c, done_c);
    end
    for (int b = 0; b < 10; b++) m_shadow[b] = m_rom(1, b);
    m_shadow[7] = m_rom(1, 7);
    m_shadow[4] = d2;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic bad;
    @(posedge clk); #1;
    preset_req = 1'b1; preset_sel = 2'd1;
    @(posedge clk); #1;
    preset_req = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({we, addr, data_out, host_ack, host_err, preset_busy, preset_done} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: we=%b addr=%h data=%h busy=%b done=%b required all 0",
               we, addr, data_out, preset_busy, preset_done);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    reset_models();
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (we || preset_busy || preset_done) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_mid_abort: writes or busy after reset release, required none");
    end
  endtask

`ifdef EQ_GAIN_SOFT_RAMP_EN
  task automatic test_ramp();
    logic [7:0] cur [10];
    logic [7:0] tgt [10];
    logic [7:0] hd;
    int  n9;
    bit  acked, done_seen, ok;
    for (int b = 0; b < 10; b++) begin
      cur[b] = m_shadow[b];
      tgt[b] = m_rom(1, b);
    end
    hd = 8'($urandom);
    n9 = 0; acked = 0; done_seen = 0;
    @(posedge clk); #1;
    preset_req = 1'b1; preset_sel = 2'd1;
    @(posedge clk); #1;
    preset_req = 1'b0; preset_sel = 2'd0;
    host_req = 1'b1; host_addr = 8'd5; host_data = hd;
    @(negedge clk);
    checks++;
    if ({preset_busy, we} !== 2'b10) begin
      errors++;
      $display("FAIL ramp_accept: busy=%b we=%b required 1 0", preset_busy, we);
    end
    for (int c = 0; c < 5000 && !done_seen; c++) begin
      @(negedge clk);
      if (host_ack) begin
        checks++;
        if ({we, addr, data_out} !== {1'b1, 8'd5, hd}) begin
          errors++;
          $display("FAIL ramp_host: we=%b addr=%h data=%h required 1 05 %h", we, addr, data_out, hd);
        end
        acked = 1; host_req = 1'b0;
        cur[5] = hd; tgt[5] = hd;
      end else if (we) begin
        ok = (addr < 8'd10) && !(acked && addr == 8'd5);
        if (ok)
          ok = (cur[addr[3:0]] < tgt[addr[3:0]] && data_out == cur[addr[3:0]] + 8'd1) ||
               (cur[addr[3:0]] > tgt[addr[3:0]] && data_out == cur[addr[3:0]] - 8'd1);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL ramp_step: addr=%h data=%h required one step toward target", addr, data_out);
        end else begin
          cur[addr[3:0]] = data_out;
          if (addr == 8'd9) n9++;
        end
      end
      if (preset_done) begin
        done_seen = 1;
        checks++;
        if (n9 != 72 || !acked || preset_busy !== 1'b0) begin
          errors++;
          $display("FAIL ramp_done: band9 steps=%0d acked=%b busy=%b required 72 1 0", n9, acked, preset_busy);
        end
      end
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL ramp_timeout: preset_done not seen, required within 5000 cycles");
    end
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (cur[b] !== tgt[b]) begin
        errors++;
        $display("FAIL ramp_final[%0d]: got %h required %h", b, cur[b], tgt[b]);
      end
      m_shadow[b] = tgt[b];
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    reset_models();
    test_reset();
    test_host_write();
    test_request_hold();
    test_consistency();
`ifdef EQ_GAIN_SOFT_RAMP_EN
    test_reset();
    test_ramp();
    test_consistency();
`else
    test_preset(1);
    test_preset(int'($urandom_range(0, 1)));
    test_consistency();
    test_collision();
    test_consistency();
    test_reset_mid();
    test_consistency();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
